dmem_access_ctrl: RTL
=====================

DMEM_ACCESS_CTRL -- requirements
Module: dmem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum BUSY cycles allowed without MemAck_in before the access is aborted.
REQ-002 Clk  input  1  sole clock, rising-edge.
REQ-003 Rst  input  1  reset, asynchronous assert, active-low.
REQ-004 MemRead_in  input  1  load request from the EX/MEM pipeline register.
REQ-005 MemWrite_in  input  1  store request from the EX/MEM pipeline register.
REQ-006 Address_in  input  32  byte address, taken from ALUResult of the EX/MEM pipeline register.
REQ-007 WriteData_in  input  32  store data, taken from ReadData2 of the EX/MEM pipeline register.
REQ-008 MemReq_out  output  1  request to data memory, registered.
REQ-009 MemWe_out  output  1  1 = write, 0 = read; valid while MemReq_out = 1.
REQ-010 MemAddr_out  output  32  captured address; valid while MemReq_out = 1.
REQ-011 MemWData_out  output  32  captured store data; valid while MemReq_out = 1.
REQ-012 MemAck_in  input  1  data memory completion, one-cycle pulse.
REQ-013 MemRData_in  input  32  read data; valid in the MemAck_in cycle.
REQ-014 Stall_out  output  1  freezes the PC and all pipeline registers up to and including EX/MEM.
REQ-015 ReadData_out  output  32  load result, held until the next load completes.
REQ-016 ReadValid_out  output  1  one-cycle pulse when ReadData_out updates.
REQ-017 BusError_out  output  1  one-cycle pulse on an aborted or illegal access.

Function
REQ-018 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-019 In IDLE, a legal request (exactly one of MemRead_in/MemWrite_in = 1, and Address_in[1:0] = 00):
- Stall_out = 1 combinationally in the same cycle.
- Address, data and direction are captured.
- Next state is BUSY.
REQ-020 In IDLE with no request: Stall_out = 0 and the state stays IDLE.
REQ-021 In BUSY:
- MemReq_out = 1 and Stall_out = 1.
- MemAddr_out, MemWData_out and MemWe_out are held constant.
REQ-022 In BUSY with MemAck_in = 1:
- A read latches MemRData_in into ReadData_out.
- Next state is DONE, and MemReq_out = 0 from that edge.
REQ-023 In DONE:
- Stall_out = 0, so the pipeline advances at the end of the cycle.
- MemRead_in and MemWrite_in are ignored.
- ReadValid_out = 1 if the access was a read.
- Next state is IDLE.
REQ-024 Minimum load/store cost: 2 stall cycles (the IDLE detect cycle plus one BUSY cycle), then DONE.
REQ-025 An 8-bit cycle counter SHALL clear on entry to BUSY and increment each BUSY cycle without MemAck_in.
REQ-026 When the counter reaches TIMEOUT_CYCLES with MemAck_in = 0:
- MemReq_out is dropped.
- BusError_out pulses in the DONE cycle.
- ReadData_out is unchanged and ReadValid_out = 0.
- Next state is DONE.
REQ-027 MemAck_in arriving in the same cycle the counter reaches TIMEOUT_CYCLES SHALL count as success, not timeout.
REQ-028 MemAck_in SHALL be ignored in IDLE and DONE.
REQ-029 An illegal request in IDLE (both MemRead_in and MemWrite_in = 1, or Address_in[1:0] != 00):
- No memory request is issued.
- Stall_out = 1 for that cycle.
- Next state is DONE, with BusError_out = 1 in DONE.

Reset
REQ-030 While Rst = 0, all of the following SHALL hold asynchronously:
- state = IDLE and counter = 0.
- MemReq_out, MemWe_out, Stall_out, ReadValid_out and BusError_out = 0.
- MemAddr_out, MemWData_out and ReadData_out = 0.
REQ-031 Reset asserted mid-access SHALL drop MemReq_out immediately, with no error pulse on release.
REQ-032 The first request after reset release SHALL be detected on the first rising edge at which Rst = 1.

Structure
REQ-033 Shared package mips_pkg SHALL hold:
- the FSM state typedef (IDLE, BUSY, DONE);
- the DMEM_TIMEOUT_DEFAULT constant (255).
REQ-034 The timeout counter SHALL be one sub-module, dmem_timeout_cnt (clear, enable, terminal-count output); all other logic stays in dmem_access_ctrl.

Verification
REQ-035 Load at address 0x00000010, MemAck_in in the first BUSY cycle with MemRData_in = 0xDEADBEEF:
- Stall_out high for 2 cycles.
- ReadData_out = 0xDEADBEEF with a 1-cycle ReadValid_out pulse.
REQ-036 Store of 0x12345678 at address 0x00000020, MemAck_in 5 cycles after entering BUSY:
- MemWe_out = 1 and MemAddr_out/MemWData_out stable throughout.
- Stall_out high for 6 cycles; no ReadValid_out.
REQ-037 TIMEOUT_CYCLES = 4, load with no MemAck_in:
- MemReq_out high for exactly 4 cycles.
- BusError_out pulses once; ReadData_out unchanged.
REQ-038 Illegal requests, each giving 1 stall cycle, MemReq_out never high, and a BusError_out pulse:
- MemRead_in = MemWrite_in = 1;
- load at address 0x00000013.
REQ-039 Rst driven low in the 2nd BUSY cycle, then released, then a load to 0x00000004:
- MemReq_out = 0 immediately on reset.
- The new access completes normally.
REQ-040 Back-to-back loads with no gap: the second request is detected only in IDLE after DONE, never in DONE.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and constants for the data-memory access path
//
// Holds the access FSM state type, the default abort limit for a memory
// access, and the request legality rule shared by the controller.

package mips_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dmem_state_t;

  localparam int unsigned DMEM_TIMEOUT_DEFAULT = 255;

  // A request is legal when it is exactly one of load/store and word aligned.
  function automatic logic req_legal(input logic rd,
                                     input logic wr,
                                     input logic [1:0] lsb);
    return (rd ^ wr) && (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/dmem_timeout_cnt.sv
// rtl/dmem_timeout_cnt.sv - 8-bit BUSY-cycle counter with terminal-count flag
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : zero the count (entry to BUSY); wins over enable
//   enable     : count one BUSY cycle that saw no acknowledge
//   tc         : this is the last BUSY cycle allowed; a further cycle
//                without acknowledge brings the count to TERMINAL

module dmem_timeout_cnt
  import mips_pkg::*;
#(
  parameter int unsigned TERMINAL = DMEM_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  // tc fires one count early so that the cycle which would make the count
  // reach TERMINAL is itself the abort cycle: TERMINAL BUSY cycles in total.
  localparam logic [7:0] TC_VALUE = 8'(TERMINAL - 1);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  assign tc = (count == TC_VALUE);

endmodule

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - MEM-stage data memory access controller with stall and timeout
//
// Ports:
//   Clk, Rst                    : clock, asynchronous active-low reset
//   MemRead_in, MemWrite_in     : load/store request from EX/MEM
//   Address_in, WriteData_in    : byte address and store data from EX/MEM
//   MemReq_out, MemWe_out       : registered request and direction to memory
//   MemAddr_out, MemWData_out   : captured address/data, held during the access
//   MemAck_in, MemRData_in      : completion pulse and load data from memory
//   Stall_out                   : freezes PC and pipeline up to EX/MEM
//   ReadData_out, ReadValid_out : load result (held) and its update pulse
//   BusError_out                : pulse for an aborted or illegal access

module dmem_access_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DMEM_TIMEOUT_DEFAULT
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        MemRead_in,
  input  logic        MemWrite_in,
  input  logic [31:0] Address_in,
  input  logic [31:0] WriteData_in,
  output logic        MemReq_out,
  output logic        MemWe_out,
  output logic [31:0] MemAddr_out,
  output logic [31:0] MemWData_out,
  input  logic        MemAck_in,
  input  logic [31:0] MemRData_in,
  output logic        Stall_out,
  output logic [31:0] ReadData_out,
  output logic        ReadValid_out,
  output logic        BusError_out
);

  dmem_state_t state;
  dmem_state_t state_next;

  logic req_any;
  logic req_ok;
  logic stall_c;
  logic cnt_clear;
  logic cnt_en;
  logic cnt_tc;
  logic timeout;

  assign req_any = MemRead_in | MemWrite_in;
  assign req_ok  = req_legal(MemRead_in, MemWrite_in, Address_in[1:0]);

  dmem_timeout_cnt #(
    .TERMINAL(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk    (Clk),
    .rst_n  (Rst),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .tc     (cnt_tc)
  );

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    stall_c    = 1'b0;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;
    timeout    = 1'b0;
    unique case (state)
      IDLE: begin
        // Any request, legal or not, holds the pipeline for this cycle.
        if (req_any) begin
          stall_c = 1'b1;
          if (req_ok) begin
            state_next = BUSY;
            cnt_clear  = 1'b1;
          end else begin
            state_next = DONE;
          end
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        // An acknowledge in the terminal cycle still counts as success.
        if (MemAck_in) begin
          state_next = DONE;
        end else begin
          cnt_en = 1'b1;
          if (cnt_tc) begin
            timeout    = 1'b1;
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Gated by reset so the stall is low while reset is held, even with a
  // request present on the inputs.
  assign Stall_out = Rst & stall_c;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      MemReq_out    <= 1'b0;
      MemWe_out     <= 1'b0;
      MemAddr_out   <= 32'd0;
      MemWData_out  <= 32'd0;
      ReadData_out  <= 32'd0;
      ReadValid_out <= 1'b0;
      BusError_out  <= 1'b0;
    end else begin
      ReadValid_out <= 1'b0;
      BusError_out  <= 1'b0;
      case (state)
        IDLE: begin
          if (req_any) begin
            if (req_ok) begin
              MemReq_out   <= 1'b1;
              MemWe_out    <= MemWrite_in;
              MemAddr_out  <= Address_in;
              MemWData_out <= WriteData_in;
            end else begin
              BusError_out <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (MemAck_in) begin
            MemReq_out <= 1'b0;
            if (!MemWe_out) begin
              ReadData_out  <= MemRData_in;
              ReadValid_out <= 1'b1;
            end
          end else if (timeout) begin
            MemReq_out   <= 1'b0;
            BusError_out <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
